// File: rtl/mandelbrot_pkg.sv
// rtl/mandelbrot_pkg.sv - shared types and Q-format constants for the frame sequencer
// Contents: sched_state_t (scheduler FSM states), coord_t (pixel coordinate),
//           depth_t (iteration count / escape depth), Q-format constants.
package mandelbrot_pkg;

  localparam int FRAC_DEFAULT        = 28;
  localparam int WORD_LENGTH_DEFAULT = 32;
  localparam int COORD_W             = 11;
  localparam int DEPTH_W             = 11;

  // Fixed-point 1.0 in the default Q4.28 coordinate format.
  localparam logic [WORD_LENGTH_DEFAULT-1:0] ONE = WORD_LENGTH_DEFAULT'(1) << FRAC_DEFAULT;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [DEPTH_W-1:0] depth_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    OUTPUT
  } sched_state_t;

endpackage

// File: rtl/pixel_scheduler_if.sv
// rtl/pixel_scheduler_if.sv - pixel result stream toward the frame-buffer writer
// Signals: pix_valid/pix_ready handshake, pix_depth escape depth, pix_x/pix_y
//          position, pix_sof on pixel (0,0), pix_eol on the last pixel of a line.
// Modports: master (scheduler side), slave (frame-buffer writer side).
interface pixel_scheduler_if;
  import mandelbrot_pkg::*;

  logic   pix_valid;
  logic   pix_ready;
  depth_t pix_depth;
  coord_t pix_x;
  coord_t pix_y;
  logic   pix_sof;
  logic   pix_eol;

  modport master (
    output pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_depth, pix_x, pix_y, pix_sof, pix_eol,
    output pix_ready
  );

endinterface

// File: rtl/pixel_scheduler_raster.sv
// rtl/pixel_scheduler_raster.sv - raster x/y counter with line and frame wrap
// Ports: sysclk, reset_n (async active-low); clear restarts at (0,0);
//        advance steps one pixel in raster order; x, y current position;
//        last_in_line, last_in_frame, first_pixel flags decoded from x/y.
module raster_counter
  import mandelbrot_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic   sysclk,
  input  logic   reset_n,
  input  logic   clear,
  input  logic   advance,
  output coord_t x,
  output coord_t y,
  output logic   last_in_line,
  output logic   last_in_frame,
  output logic   first_pixel
);

  localparam coord_t X_LAST = coord_t'(H_RES - 1);
  localparam coord_t Y_LAST = coord_t'(V_RES - 1);

  assign last_in_line  = (x == X_LAST);
  assign last_in_frame = last_in_line && (y == Y_LAST);
  assign first_pixel   = (x == '0) && (y == '0);

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (!last_in_line) begin
        x <= x + coord_t'(1);
      end else begin
        x <= '0;
        y <= last_in_frame ? '0 : y + coord_t'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_scheduler.sv
// rtl/pixel_scheduler.sv - frame sequencer feeding depth_calculator, one pixel in flight
// Ports: sysclk, reset_n (async active-low); frame_start with re_min/im_max/step/
//        max_iter_in frame config; calc_* launch/result link to the depth calculator;
//        pix (master) result stream; busy across a frame; frame_done end pulse.
module pixel_scheduler
  import mandelbrot_pkg::*;
#(
  parameter int FRAC        = FRAC_DEFAULT,
  parameter int WORD_LENGTH = WORD_LENGTH_DEFAULT,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                          sysclk,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic signed [WORD_LENGTH-1:0] re_min,
  input  logic signed [WORD_LENGTH-1:0] im_max,
  input  logic signed [WORD_LENGTH-1:0] step,
  input  depth_t                        max_iter_in,
  output logic                          calc_start,
  output coord_t                        calc_x,
  output coord_t                        calc_y,
  output logic signed [WORD_LENGTH-1:0] calc_re_c,
  output logic signed [WORD_LENGTH-1:0] calc_im_c,
  output depth_t                        calc_max_iter,
  input  logic                          calc_done,
  input  depth_t                        calc_depth,
  pixel_scheduler_if.master             pix,
  output logic                          busy,
  output logic                          frame_done
);

  if (FRAC < 1 || FRAC >= WORD_LENGTH || H_RES < 1 || H_RES > 2047 ||
      V_RES < 1 || V_RES > 2047) begin : g_param_check
    $error("pixel_scheduler: FRAC, H_RES or V_RES out of range");
  end

  sched_state_t                  state;
  logic signed [WORD_LENGTH-1:0] re_min_q;
  logic signed [WORD_LENGTH-1:0] step_q;

  coord_t x;
  coord_t y;
  logic   last_in_line;
  logic   last_in_frame;
  logic   first_pixel;
  logic   handshake;
  logic   accept;
  logic   advance;

  assign handshake = pix.pix_valid && pix.pix_ready;
  assign accept    = (state == IDLE) && frame_start;
  // The counter is not stepped past the final pixel; the next accept clears it.
  assign advance   = (state == OUTPUT) && handshake && !last_in_frame;

  assign calc_x = x;
  assign calc_y = y;

  raster_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_raster (
    .sysclk        (sysclk),
    .reset_n       (reset_n),
    .clear         (accept),
    .advance       (advance),
    .x             (x),
    .y             (y),
    .last_in_line  (last_in_line),
    .last_in_frame (last_in_frame),
    .first_pixel   (first_pixel)
  );

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      re_min_q      <= '0;
      step_q        <= '0;
      calc_start    <= 1'b0;
      calc_re_c     <= '0;
      calc_im_c     <= '0;
      calc_max_iter <= '0;
      pix.pix_valid <= 1'b0;
      pix.pix_depth <= '0;
      pix.pix_x     <= '0;
      pix.pix_y     <= '0;
      pix.pix_sof   <= 1'b0;
      pix.pix_eol   <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_start) begin
            re_min_q      <= re_min;
            step_q        <= step;
            calc_max_iter <= max_iter_in;
            calc_re_c     <= re_min;
            calc_im_c     <= im_max;
            busy          <= 1'b1;
            // First launch of a frame is raised on entry so it follows
            // frame_start by one cycle.
            calc_start    <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          // Entered with calc_start low after a handshake: raise it for one
          // cycle, then wait. Entered with it high from IDLE: drop it and wait.
          calc_start <= !calc_start;
          if (calc_start) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (calc_done) begin
            pix.pix_valid <= 1'b1;
            pix.pix_depth <= calc_depth;
            pix.pix_x     <= x;
            pix.pix_y     <= y;
            pix.pix_sof   <= first_pixel;
            pix.pix_eol   <= last_in_line;
            state         <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (handshake) begin
            pix.pix_valid <= 1'b0;
            if (!last_in_line) begin
              calc_re_c <= calc_re_c + step_q;
              state     <= ISSUE;
            end else if (!last_in_frame) begin
              calc_re_c <= re_min_q;
              calc_im_c <= calc_im_c - step_q;
              state     <= ISSUE;
            end else begin
              frame_done <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb/tb_pixel_scheduler.sv - self-checking bench for pixel_scheduler (4x3 and 1x1 rasters)
module tb_pixel_scheduler;
  import mandelbrot_pkg::*;

  localparam int H   = 4;
  localparam int V   = 3;
  localparam int LAT = 5;

  logic        sysclk;
  logic        reset_n;
  logic        frame_start;
  logic [31:0] re_min;
  logic [31:0] im_max;
  logic [31:0] step;
  logic [10:0] max_iter_in;

  logic        calc_start;
  logic [10:0] calc_x;
  logic [10:0] calc_y;
  logic [31:0] calc_re_c;
  logic [31:0] calc_im_c;
  logic [10:0] calc_max_iter;
  logic        calc_done;
  logic [10:0] calc_depth;
  logic        busy;
  logic        frame_done;
  logic        model_done;
  logic        inj_done;

  logic        frame_start1;
  logic        calc_start1;
  logic [10:0] calc_x1;
  logic [10:0] calc_y1;
  logic [31:0] calc_re_c1;
  logic [31:0] calc_im_c1;
  logic [10:0] calc_max_iter1;
  logic        calc_done1;
  logic [10:0] calc_depth1;
  logic        busy1;
  logic        frame_done1;

  pixel_scheduler_if pif ();
  pixel_scheduler_if pif1 ();

  assign calc_done = model_done | inj_done;

  pixel_scheduler #(.FRAC(28), .WORD_LENGTH(32), .H_RES(H), .V_RES(V)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
    .re_min(re_min), .im_max(im_max), .step(step), .max_iter_in(max_iter_in),
    .calc_start(calc_start), .calc_x(calc_x), .calc_y(calc_y),
    .calc_re_c(calc_re_c), .calc_im_c(calc_im_c), .calc_max_iter(calc_max_iter),
    .calc_done(calc_done), .calc_depth(calc_depth), .pix(pif),
    .busy(busy), .frame_done(frame_done)
  );

  pixel_scheduler #(.FRAC(28), .WORD_LENGTH(32), .H_RES(1), .V_RES(1)) dut1 (
    .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start1),
    .re_min(re_min), .im_max(im_max), .step(step), .max_iter_in(max_iter_in),
    .calc_start(calc_start1), .calc_x(calc_x1), .calc_y(calc_y1),
    .calc_re_c(calc_re_c1), .calc_im_c(calc_im_c1), .calc_max_iter(calc_max_iter1),
    .calc_done(calc_done1), .calc_depth(calc_depth1), .pix(pif1),
    .busy(busy1), .frame_done(frame_done1)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int          errors = 0;
  int          checks = 0;
  int          stab_err = 0;
  logic [10:0] salt = '0;

  function automatic logic [10:0] depth_of(input int x, input int y, input logic [10:0] s);
    return 11'(x * 37 + y * 101) ^ s;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Depth calculator stand-in: fixed latency, depth derived from the pixel
  // position, and a running tally of any drift in c / max_iter while busy.
  logic        active;
  int          cnt;
  logic [31:0] h_re;
  logic [31:0] h_im;
  logic [10:0] h_mi;
  logic [10:0] h_x;
  logic [10:0] h_y;

  always @(negedge sysclk) begin
    if (!reset_n) begin
      active     = 1'b0;
      cnt        = 0;
      model_done = 1'b0;
      calc_depth = '0;
    end else begin
      model_done = 1'b0;
      if (active) begin
        if ({calc_re_c, calc_im_c, calc_max_iter} !== {h_re, h_im, h_mi}) stab_err++;
        cnt++;
        if (cnt == LAT) begin
          model_done = 1'b1;
          calc_depth = depth_of(int'(h_x), int'(h_y), salt);
          active     = 1'b0;
        end
      end else if (calc_start) begin
        active = 1'b1;
        cnt    = 0;
        h_re   = calc_re_c;
        h_im   = calc_im_c;
        h_mi   = calc_max_iter;
        h_x    = calc_x;
        h_y    = calc_y;
      end
    end
  end

  task automatic run_frame(input logic [31:0] rmin, input logic [31:0] imax,
                           input logic [31:0] stp, input logic [10:0] mi,
                           input int sx, input int sy, input bit mid_change,
                           input bit retrig);
    int           budget;
    int           bad;
    logic [34:0]  snap;
    @(negedge sysclk);
    re_min = rmin; im_max = imax; step = stp; max_iter_in = mi;
    salt = 11'($urandom);
    frame_start = 1'b1;
    @(negedge sysclk);
    frame_start = 1'b0;
    if (mid_change) begin
      re_min = $urandom; im_max = $urandom; step = $urandom; max_iter_in = 11'($urandom);
    end
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        budget = 0;
        while (!calc_start && budget < 40) begin
          @(negedge sysclk);
          budget++;
        end
        if (x == 0 && y == 0) check("start_latency", budget, 0);
        check("calc_xy", {calc_start, calc_x, calc_y}, {1'b1, 11'(x), 11'(y)});
        check("calc_c", {calc_re_c, calc_im_c, calc_max_iter, busy},
              {rmin + 32'(x) * stp, imax - 32'(y) * stp, mi, 1'b1});
        if (rmin == 32'h7FF00000 && stp == 32'h00200000 && x == 1 && y == 0)
          check("re_wrap", calc_re_c, 32'h80100000);
        if (x == sx && y == sy) pif.pix_ready = 1'b0;
        if (retrig && x == 1 && y == 1) begin
          @(negedge sysclk);
          frame_start = 1'b1;
          @(negedge sysclk);
          frame_start = 1'b0;
        end
        budget = 0;
        while (!pif.pix_valid && budget < 40) begin
          @(negedge sysclk);
          budget++;
        end
        check("pix", {pif.pix_valid, pif.pix_x, pif.pix_y, pif.pix_depth, pif.pix_sof, pif.pix_eol},
              {1'b1, 11'(x), 11'(y), depth_of(x, y, salt), (x == 0 && y == 0), (x == H - 1)});
        if (!pif.pix_ready) begin
          snap = {pif.pix_x, pif.pix_y, pif.pix_depth, pif.pix_sof, pif.pix_eol};
          bad  = 0;
          repeat (10) begin
            @(negedge sysclk);
            if ({pif.pix_valid, calc_start, pif.pix_x, pif.pix_y, pif.pix_depth,
                 pif.pix_sof, pif.pix_eol} !== {1'b1, 1'b0, snap}) bad++;
          end
          check("stall_hold", bad, 0);
          pif.pix_ready = 1'b1;
        end
        @(negedge sysclk);
        if (x == H - 1 && y == V - 1) begin
          check("frame_end", {frame_done, busy, pif.pix_valid, calc_start}, 4'b1000);
        end else begin
          check("issue_gap", {calc_start, frame_done, pif.pix_valid}, 3'b000);
          @(negedge sysclk);
          check("restart_latency", calc_start, 1'b1);
        end
      end
    end
  endtask

  initial begin
    int          budget;
    int          bad;
    logic [31:0] r1;
    logic [31:0] i1;
    logic [10:0] m1;
    logic [10:0] d1;

    reset_n = 1'b0; frame_start = 1'b0; frame_start1 = 1'b0;
    re_min = '0; im_max = '0; step = '0; max_iter_in = '0;
    inj_done = 1'b0; calc_done1 = 1'b0; calc_depth1 = '0;
    pif.pix_ready = 1'b1; pif1.pix_ready = 1'b1;
    repeat (3) @(negedge sysclk);
    check("reset_outputs",
          {calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter, pif.pix_valid,
           pif.pix_depth, pif.pix_x, pif.pix_y, pif.pix_sof, pif.pix_eol, busy, frame_done}, '0);
    check("reset_outputs_1x1",
          {calc_start1, calc_re_c1, calc_im_c1, pif1.pix_valid, busy1, frame_done1}, '0);
    reset_n = 1'b1;

    // Basic frame with a 10-cycle stall on (2,1); then a frame with mid-frame
    // config changes and an ignored re-trigger, started the cycle after
    // frame_done; then a frame whose real part wraps past +max.
    run_frame(32'hE0000000, 32'h10000000, 32'h00200000, 11'd100, 2, 1, 1'b0, 1'b0);
    run_frame($urandom, $urandom, $urandom, 11'($urandom), -1, -1, 1'b1, 1'b1);
    run_frame(32'h7FF00000, $urandom, 32'h00200000, 11'($urandom), -1, -1, 1'b0, 1'b0);

    bad = 0;
    repeat (8) begin
      @(negedge sysclk);
      if ({calc_start, pif.pix_valid, busy} !== 3'b000) bad++;
    end
    check("idle_after_frames", bad, 0);

    // Degenerate 1x1 frame.
    r1 = $urandom; i1 = $urandom; m1 = 11'($urandom); d1 = 11'($urandom);
    @(negedge sysclk);
    re_min = r1; im_max = i1; max_iter_in = m1; step = $urandom;
    frame_start1 = 1'b1;
    @(negedge sysclk);
    frame_start1 = 1'b0;
    check("one_issue", {calc_start1, busy1, calc_x1, calc_y1, calc_re_c1, calc_im_c1, calc_max_iter1},
          {1'b1, 1'b1, 22'd0, r1, i1, m1});
    repeat (3) @(negedge sysclk);
    calc_depth1 = d1; calc_done1 = 1'b1;
    @(negedge sysclk);
    calc_done1 = 1'b0;
    check("one_pix", {pif1.pix_valid, pif1.pix_x, pif1.pix_y, pif1.pix_depth, pif1.pix_sof, pif1.pix_eol},
          {1'b1, 22'd0, d1, 1'b1, 1'b1});
    @(negedge sysclk);
    check("one_done", {frame_done1, busy1, pif1.pix_valid, calc_start1}, 4'b1000);

    // Reset while pixel (1,1) is being calculated.
    @(negedge sysclk);
    re_min = $urandom; im_max = $urandom; step = $urandom; max_iter_in = 11'($urandom | 1);
    salt = 11'($urandom);
    frame_start = 1'b1;
    @(negedge sysclk);
    frame_start = 1'b0;
    budget = 0;
    while (!(calc_start && calc_x == 11'd1 && calc_y == 11'd1) && budget < 400) begin
      @(negedge sysclk);
      budget++;
    end
    check("reach_1_1", {calc_start, calc_x, calc_y}, {1'b1, 11'd1, 11'd1});
    @(negedge sysclk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset",
          {calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter, pif.pix_valid,
           pif.pix_depth, pif.pix_x, pif.pix_y, pif.pix_sof, pif.pix_eol, busy, frame_done}, '0);
    @(negedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b1;
    @(negedge sysclk);
    inj_done = 1'b1;
    @(negedge sysclk);
    inj_done = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge sysclk);
      if ({pif.pix_valid, calc_start, busy} !== 3'b000) bad++;
    end
    check("stray_done_ignored", bad, 0);

    check("calc_stable", stab_err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
